// File: rtl/fpu_ctrl_pkg.sv
// fpu_ctrl_pkg: opcodes, default latency table and FSM state type for the FPU latency controller
package fpu_ctrl_pkg;

    localparam logic [3:0] FADD  = 4'd0;
    localparam logic [3:0] FSUB  = 4'd1;
    localparam logic [3:0] FMUL  = 4'd2;
    localparam logic [3:0] FMADD = 4'd3;
    localparam logic [3:0] FMV   = 4'd4;
    localparam logic [3:0] FSGNJ = 4'd5;
    localparam logic [3:0] FDIV  = 4'd6;
    localparam logic [3:0] FCMP  = 4'd7;
    localparam logic [3:0] FCVT  = 4'd8;
    localparam logic [3:0] FSQRT = 4'd9;

    // 16 entries x 5 bits, entry i at bits [i*5 +: 5]
    localparam logic [79:0] FPU_LAT_DEFAULT = {
        30'd0,
        5'd6, 5'd6, 5'd1, 5'd16, 5'd1,
        5'd0, 5'd6, 5'd5, 5'd7,  5'd7
    };

    typedef enum logic {IDLE, BUSY} fpu_state_e;

endpackage

// File: rtl/fpu_latency_ctrl_if.sv
// fpu_latency_ctrl_if: execute-stage to FPU controller handshake; latency write port with FPU_LAT_CSR_EN
interface fpu_latency_ctrl_if #(
    parameter int OP_W  = 4,
    parameter int CNT_W = 5
);
    logic             fpu_sel;
    logic [OP_W-1:0]  fpuOp;
    logic             flush;
    logic             fpu_inprogress;
    logic             fpu_done;
    logic [CNT_W-1:0] fpu_count;
`ifdef FPU_LAT_CSR_EN
    logic             lat_we;
    logic [OP_W-1:0]  lat_waddr;
    logic [CNT_W-1:0] lat_wdata;

    modport master (output fpu_sel, fpuOp, flush, lat_we, lat_waddr, lat_wdata,
                    input  fpu_inprogress, fpu_done, fpu_count);
    modport slave  (input  fpu_sel, fpuOp, flush, lat_we, lat_waddr, lat_wdata,
                    output fpu_inprogress, fpu_done, fpu_count);
`else
    modport master (output fpu_sel, fpuOp, flush,
                    input  fpu_inprogress, fpu_done, fpu_count);
    modport slave  (input  fpu_sel, fpuOp, flush,
                    output fpu_inprogress, fpu_done, fpu_count);
`endif
endinterface

// File: rtl/fpu_lat_table.sv
// fpu_lat_table: per-opcode latency lookup; register file with write port when FPU_LAT_CSR_EN is defined
module fpu_lat_table #(
    parameter int                       OP_W      = 4,
    parameter int                       NUM_OPS   = 16,
    parameter int                       CNT_W     = 5,
    parameter logic [NUM_OPS*CNT_W-1:0] LAT_TABLE = fpu_ctrl_pkg::FPU_LAT_DEFAULT
) (
`ifdef FPU_LAT_CSR_EN
    input  logic             clock,
    input  logic             clear,
    input  logic             i_we,
    input  logic [OP_W-1:0]  i_waddr,
    input  logic [CNT_W-1:0] i_wdata,
`endif
    input  logic [OP_W-1:0]  i_raddr,
    output logic [CNT_W-1:0] o_rdata
);

`ifdef FPU_LAT_CSR_EN
    logic [CNT_W-1:0] r_tab [NUM_OPS];

    // reload defaults on reset, otherwise accept in-range writes
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NUM_OPS; i++) r_tab[i] <= LAT_TABLE[i*CNT_W +: CNT_W];
        end else if (i_we && int'(i_waddr) < NUM_OPS) begin
            r_tab[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = (int'(i_raddr) < NUM_OPS) ? r_tab[i_raddr] : '0;
`else
    assign o_rdata = (int'(i_raddr) < NUM_OPS) ? LAT_TABLE[int'(i_raddr)*CNT_W +: CNT_W] : '0;
`endif

endmodule

// File: rtl/fpu_latency_ctrl.sv
// fpu_latency_ctrl: stalls the pipeline for multi-cycle FPU ops and strobes done; FPU_LAT_CSR_EN adds a writable latency table
module fpu_latency_ctrl
    import fpu_ctrl_pkg::*;
#(
    parameter int                       OP_W      = 4,
    parameter int                       NUM_OPS   = 16,
    parameter int                       CNT_W     = 5,
    parameter logic [NUM_OPS*CNT_W-1:0] LAT_TABLE = FPU_LAT_DEFAULT
) (
    input logic                clock,
    input logic                clear,
    fpu_latency_ctrl_if.slave  bus
);

    fpu_state_e       r_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_lat_q;
    logic [CNT_W-1:0] w_lat;
    logic             w_issue;
    logic             w_run;
    logic             w_last;

    fpu_lat_table #(
        .OP_W      (OP_W),
        .NUM_OPS   (NUM_OPS),
        .CNT_W     (CNT_W),
        .LAT_TABLE (LAT_TABLE)
    ) u_table (
`ifdef FPU_LAT_CSR_EN
        .clock   (clock),
        .clear   (clear),
        .i_we    (bus.lat_we),
        .i_waddr (bus.lat_waddr),
        .i_wdata (bus.lat_wdata),
`endif
        .i_raddr (bus.fpuOp),
        .o_rdata (w_lat)
    );

    // flush or a dropped fpu_sel kills the op; reset silences the outputs immediately
    assign w_issue = clear && r_state == IDLE && bus.fpu_sel && !bus.flush;
    assign w_run   = clear && r_state == BUSY && bus.fpu_sel && !bus.flush;
    assign w_last  = r_count == r_lat_q - CNT_W'(1);

    assign bus.fpu_inprogress = w_issue ? (w_lat >= CNT_W'(2)) : (w_run && r_count < r_lat_q - CNT_W'(1));
    assign bus.fpu_done       = w_issue ? (w_lat <= CNT_W'(1)) : (w_run && w_last);
    assign bus.fpu_count      = r_count;

    // latch latency at issue, count up to L-1, return to IDLE on completion or abort
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= IDLE;
            r_count <= '0;
            r_lat_q <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_issue && w_lat >= CNT_W'(2)) begin
                    r_state <= BUSY;
                    r_lat_q <= w_lat;
                    r_count <= CNT_W'(1);
                end
                BUSY: if (!w_run || w_last) begin
                    r_state <= IDLE;
                    r_count <= '0;
                end else begin
                    r_count <= r_count + CNT_W'(1);
                end
            endcase
        end
    end

endmodule
